// File: rtl/fm_sample_seq.sv
// Sine-tone sample sequencer: phase accumulator + quarter-wave LUT feeding fm_out (FM_SAMPLE_SEQ_RAMP_EN: sawtooth, no LUT).
// Latency: a divider tick in cycle T produces update/data in cycle T+2; SAMPLE_DIV cycles per sample.
// Backpressure: none; the fm_out consumer always accepts, sync cancels any pending sample.
module fm_sample_seq #(
   parameter int SAMPLE_DIV = 500,
   parameter int CNT_W      = 9
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic       enable,
   input  logic       sync,
   input  logic [7:0] step,
   output logic [7:0] data,
   output logic       update
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

   logic [CNT_W-1:0] cnt;
   logic [7:0]       phase;
   logic             vld;
   logic             tick;
   logic [7:0]       sample;

   assign tick = enable && (cnt == CNT_LAST);

`ifdef FM_SAMPLE_SEQ_RAMP_EN
   assign sample = phase;
`else
   // Q[k] = round(127*sin(2*pi*(k+0.5)/256)); half-sample offset keeps the wave symmetric without a zero entry
   localparam logic [6:0] QTAB [64] = '{
        7'd2,   7'd5,   7'd8,  7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
       7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
       7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
       7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
       7'd91,  7'd93,  7'd95,  7'd97,  7'd99, 7'd101, 7'd103, 7'd105,
      7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
      7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
      7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
   };

   logic [5:0] q_idx;
   logic [6:0] q_mag;

   always_comb begin
      // odd quadrants read the table backwards (63-k == ~k for 6 bits)
      q_idx  = phase[6] ? ~phase[5:0] : phase[5:0];
      q_mag  = QTAB[q_idx];
      sample = phase[7] ? (8'd128 - {1'b0, q_mag}) : (8'd128 + {1'b0, q_mag});
   end
`endif

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         cnt    <= '0;
         phase  <= 8'h00;
         vld    <= 1'b0;
         data   <= 8'h80;
         update <= 1'b0;
      end else begin
         update <= vld && !sync;
         if (vld && !sync) begin
            data <= sample;
         end
         if (sync) begin
            cnt   <= '0;
            phase <= 8'h00;
            vld   <= 1'b0;
         end else begin
            if (!enable || cnt == CNT_LAST) begin
               cnt <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
            if (tick) begin
               phase <= phase + step;
            end
            vld <= tick;
         end
      end
   end

endmodule

// File: tb/tb_fm_sample_seq.sv
// Bench for fm_sample_seq: random stimulus, trigonometric reference model, queue scoreboard plus directed scenarios.
module tb_fm_sample_seq;

   localparam int  DIV = 4;
   localparam real PI  = 3.14159265358979323846;

   logic       clk;
   logic       nRst;
   logic       enable;
   logic       sync;
   logic [7:0] step;
   logic [7:0] data;
   logic       update;

   fm_sample_seq #(.SAMPLE_DIV(DIV), .CNT_W(2)) dut (
      .clk    (clk),
      .nRst   (nRst),
      .enable (enable),
      .sync   (sync),
      .step   (step),
      .data   (data),
      .update (update)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         due;
      logic [7:0] d;
   } ent_t;

   ent_t       exp_q [$];
   ent_t       obs_q [$];
   int         ecount;
   int         errors;
   int         checks;
   logic [7:0] last_exp;

   int         m_cnt;
   int         m_phase;

   task automatic chk(input bit ok, input string name, input int act, input int req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, ecount);
      end
   endtask

   // Expected sample straight from the math: 128 + round(127*sin(2*pi*(p+0.5)/256)).
   function automatic logic [7:0] ref_sample(input int p);
      real r;
      int  q;
      r = 127.0 * $sin(2.0 * PI * (real'(p) + 0.5) / 256.0);
      q = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
`ifdef FM_SAMPLE_SEQ_RAMP_EN
      return 8'(p);
`else
      return 8'(128 + q);
`endif
   endfunction

   // Reference: a sample is taken on every DIV-th consecutive enabled cycle since reset/sync/enable-low.
   always @(posedge clk) begin
      ecount++;
      if (!nRst) begin
         exp_q.delete();
         m_cnt    = 0;
         m_phase  = 0;
         last_exp = 8'h80;
      end else if (sync) begin
         m_cnt   = 0;
         m_phase = 0;
         if (exp_q.size() > 0 && exp_q[exp_q.size()-1].due == ecount)
            void'(exp_q.pop_back());
      end else if (enable) begin
         m_cnt++;
         if (m_cnt == DIV) begin
            m_cnt   = 0;
            m_phase = (m_phase + int'(step)) % 256;
            exp_q.push_back('{ecount + 1, ref_sample(m_phase)});
         end
      end else begin
         m_cnt = 0;
      end
   end

   // Monitor: pops the scoreboard whenever the DUT strobes update.
   always @(posedge clk) begin
      ent_t e;
      #1;
      if (!nRst) begin
         chk(update == 1'b0, "reset_update", int'(update), 0);
         chk(data == 8'h80, "reset_data", int'(data), 128);
      end else begin
         if (update) begin
            obs_q.push_back('{ecount, data});
            if (exp_q.size() == 0 || exp_q[0].due != ecount) begin
               chk(update == 1'b0, "unexpected_update", int'(update), 0);
            end else begin
               e = exp_q.pop_front();
               chk(data == e.d, "sample_data", int'(data), int'(e.d));
               last_exp = e.d;
            end
         end else if (exp_q.size() > 0 && exp_q[0].due == ecount) begin
            chk(update == 1'b1, "missing_update", int'(update), 1);
            e = exp_q.pop_front();
            last_exp = e.d;
         end
         chk(data == last_exp, "data_hold", int'(data), int'(last_exp));
      end
   end

   task automatic pulse_sync();
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
   endtask

   logic [7:0] quad_exp [4];
   logic [7:0] dc_exp;
   logic [7:0] first_exp;
   int         t0;

   initial begin
`ifdef FM_SAMPLE_SEQ_RAMP_EN
      quad_exp  = '{8'd64, 8'd128, 8'd192, 8'd0};
      dc_exp    = 8'd0;
      first_exp = 8'd64;
`else
      quad_exp  = '{8'd255, 8'd126, 8'd1, 8'd130};
      dc_exp    = 8'd130;
      first_exp = 8'd255;
`endif
      ecount = 0; errors = 0; checks = 0;
      m_cnt = 0; m_phase = 0; last_exp = 8'h80;
      nRst = 1'b0; enable = 1'b0; sync = 1'b0; step = 8'd0;

      // Reset then long idle: data must sit at midscale with no strobes
      repeat (5) @(negedge clk);
      nRst = 1'b1;
      repeat (2000) @(negedge clk);
      chk(obs_q.size() == 0, "idle_updates", obs_q.size(), 0);

      // Quadrants: step=64 from phase 0
      obs_q.delete();
      step = 8'd64; enable = 1'b1; t0 = ecount;
      repeat (8 * DIV + 2) @(negedge clk);
      chk(obs_q.size() >= 8, "quad_count", obs_q.size(), 8);
      if (obs_q.size() >= 8) begin
         chk(obs_q[0].due == t0 + 5, "quad_first_latency", obs_q[0].due - t0, 5);
         for (int i = 0; i < 8; i++) begin
            chk(obs_q[i].d == quad_exp[i % 4], "quad_data", int'(obs_q[i].d), int'(quad_exp[i % 4]));
            if (i > 0)
               chk(obs_q[i].due - obs_q[i-1].due == DIV, "quad_period", obs_q[i].due - obs_q[i-1].due, DIV);
         end
      end

      // DC tone: step=0 from phase 0
      enable = 1'b0; step = 8'd0;
      pulse_sync();
      obs_q.delete();
      enable = 1'b1;
      repeat (5 * DIV) @(negedge clk);
      chk(obs_q.size() >= 4, "dc_count", obs_q.size(), 4);
      foreach (obs_q[i]) begin
         chk(obs_q[i].d == dc_exp, "dc_data", int'(obs_q[i].d), int'(dc_exp));
         if (i > 0)
            chk(obs_q[i].due - obs_q[i-1].due == DIV, "dc_period", obs_q[i].due - obs_q[i-1].due, DIV);
      end

      // Sync coincident with a tick discards it
      step = 8'd64;
      pulse_sync();
      repeat (DIV - 1) @(negedge clk);
      obs_q.delete();
      pulse_sync();
      t0 = ecount;
      repeat (DIV + 3) @(negedge clk);
      chk(obs_q.size() >= 1, "sync_next_update", obs_q.size(), 1);
      if (obs_q.size() >= 1) begin
         chk(obs_q[0].due == t0 + DIV + 1, "sync_next_latency", obs_q[0].due - t0 + 1, DIV + 2);
         chk(obs_q[0].d == first_exp, "sync_next_data", int'(obs_q[0].d), int'(first_exp));
      end

      // Enable dropped the cycle after a tick: that sample still completes
      pulse_sync();
      t0 = ecount;
      repeat (DIV) @(negedge clk);
      enable = 1'b0;
      obs_q.delete();
      repeat (3 * DIV) @(negedge clk);
      chk(obs_q.size() == 1, "enable_drop_count", obs_q.size(), 1);
      if (obs_q.size() >= 1)
         chk(obs_q[0].due == t0 + DIV + 1, "enable_drop_edge", obs_q[0].due - t0, DIV + 1);

      // Ramp check: step=1 walks phase through every value
      step = 8'd1;
      pulse_sync();
      obs_q.delete();
      enable = 1'b1;
      repeat (258 * DIV) @(negedge clk);
      chk(obs_q.size() >= 257, "step1_count", obs_q.size(), 257);
`ifdef FM_SAMPLE_SEQ_RAMP_EN
      foreach (obs_q[i])
         chk(int'(obs_q[i].d) == (i + 1) % 256, "ramp_data", int'(obs_q[i].d), (i + 1) % 256);
`endif

      // Reset while update is high: it must drop without a clock edge
      pulse_sync();
      repeat (DIV + 1) @(negedge clk);
      nRst = 1'b0;
      #1;
      chk(update == 1'b0, "async_reset_update", int'(update), 0);
      chk(data == 8'h80, "async_reset_data", int'(data), 128);
      @(negedge clk);
      nRst = 1'b1;

      // Random traffic
      for (int n = 0; n < 4000; n++) begin
         enable = ($urandom_range(0, 9) != 0);
         sync   = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 15) == 0)
            step = 8'($urandom);
         if ($urandom_range(0, 799) == 0)
            nRst = 1'b0;
         else
            nRst = 1'b1;
         @(negedge clk);
      end
      nRst = 1'b1; sync = 1'b0; enable = 1'b0;
      repeat (DIV + 4) @(negedge clk);
      chk(exp_q.size() == 0, "drain_pending", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
